pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the stall and flush inputs
//  of the IF, ID and EX pipeline registers. Covers:
//  - load-use hazards between the instruction being decoded and a load in EX;
//  - taken branch/jump redirects resolved in EX;
//  - data-memory wait states, with a timeout fault.

---
 rtl/pipeline_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, EX redirects and data-memory waits.
// Control outputs are combinational from state + inputs; perf counters are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 2,
  parameter int unsigned MEM_TIMEOUT      = 255,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_rs1_addr_IF,
  input  logic [4:0]       i_rs2_addr_IF,
  input  logic             i_use_rs1_IF,
  input  logic             i_use_rs2_IF,
  input  logic [4:0]       i_rd_EX,
  input  logic             i_is_load_EX,
  input  logic             i_redirect_EX,
  input  logic             i_dm_req_MEM,
  input  logic             i_dm_ready_MEM,
  output logic             o_stall_IF,
  output logic             o_stall_ID,
  output logic             o_stall_EX,
  output logic             o_flush_ID,
  output logic             o_flush_EX,
  output logic             o_pc_redirect,
  output logic             o_fault,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int unsigned BUB_W  = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES + 1) : 1;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_REDIRECT = 2'd2,
    S_FAULT    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [BUB_W-1:0]  r_bub_cnt;
  logic [BUB_W-1:0]  w_bub_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_mem_wait;
  logic              w_load_use;

  assign w_mem_wait = i_dm_req_MEM & ~i_dm_ready_MEM;
  assign w_load_use = i_is_load_EX & (i_rd_EX != 5'd0) &
                      ((i_use_rs1_IF & (i_rs1_addr_IF == i_rd_EX)) |
                       (i_use_rs2_IF & (i_rs2_addr_IF == i_rd_EX)));

  // State register and wait/bubble counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_bub_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_bub_cnt  <= w_bub_cnt_nxt;
    end
  end

  // Next-state and control outputs; wait_cnt counts consecutive waiting cycles incl. the first one in RUN
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_bub_cnt_nxt  = r_bub_cnt;
    o_stall_IF     = 1'b0;
    o_stall_ID     = 1'b0;
    o_stall_EX     = 1'b0;
    o_flush_ID     = 1'b0;
    o_flush_EX     = 1'b0;
    o_pc_redirect  = 1'b0;
    o_fault        = 1'b0;
    if (!i_reset) begin
      case (r_state)
        S_RUN: begin
          if (w_mem_wait) begin
            o_stall_IF     = 1'b1;
            o_stall_ID     = 1'b1;
            o_stall_EX     = 1'b1;
            w_wait_cnt_nxt = WAIT_W'(1);
            w_state_nxt    = (MEM_TIMEOUT <= 1) ? S_FAULT : S_MEM_WAIT;
          end else if (i_redirect_EX) begin
            o_pc_redirect = 1'b1;
            o_flush_ID    = 1'b1;
            o_flush_EX    = 1'b1;
            if (REDIRECT_BUBBLES > 1) begin
              w_state_nxt   = S_REDIRECT;
              w_bub_cnt_nxt = BUB_W'(REDIRECT_BUBBLES - 1);
            end
          end else if (w_load_use) begin
            o_stall_IF = 1'b1;
            o_flush_ID = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (w_mem_wait) begin
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_stall_EX = 1'b1;
            if ((32'(r_wait_cnt) + 32'd1) >= MEM_TIMEOUT) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
            end
          end else begin
            w_state_nxt    = S_RUN;
            w_wait_cnt_nxt = '0;
          end
        end
        S_REDIRECT: begin
          if (w_mem_wait) begin
            o_stall_IF = 1'b1;
            o_stall_ID = 1'b1;
            o_stall_EX = 1'b1;
          end else begin
            o_flush_ID = 1'b1;
            if (r_bub_cnt <= BUB_W'(1)) begin
              w_state_nxt   = S_RUN;
              w_bub_cnt_nxt = '0;
            end else begin
              w_bub_cnt_nxt = r_bub_cnt - BUB_W'(1);
            end
          end
        end
        S_FAULT: begin
          o_stall_IF = 1'b1;
          o_stall_ID = 1'b1;
          o_stall_EX = 1'b1;
          o_fault    = 1'b1;
        end
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  // Saturating performance counters
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall_IF && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (o_flush_ID && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Table-driven bench for pipeline_hazard_ctrl with an expected-value scoreboard.
// Two instances: default parameters, and MEM_TIMEOUT=3 for the fault path.
module tb_pipeline_hazard_ctrl;

  // Control vector bit order: {stall_IF, stall_ID, stall_EX, flush_ID, flush_EX, pc_redirect, fault}
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1001000;
  localparam logic [6:0] O_RD0  = 7'b0001110;
  localparam logic [6:0] O_RD1  = 7'b0001000;
  localparam logic [6:0] O_ST   = 7'b1110000;
  localparam logic [6:0] O_FT   = 7'b1110001;

  typedef struct {
    logic       sel;
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       rdr;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic        sel;
    logic [6:0]  exp;
    logic        chk_cnt;
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
  } sb_t;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_addr_IF, rs2_addr_IF, rd_EX;
  logic       use_rs1_IF, use_rs2_IF, is_load_EX, redirect_EX, dm_req_MEM, dm_ready_MEM;

  logic        a_stall_IF, a_stall_ID, a_stall_EX, a_flush_ID, a_flush_EX, a_pc_redirect, a_fault;
  logic [31:0] a_stall_cnt, a_flush_cnt;
  logic        b_stall_IF, b_stall_ID, b_stall_EX, b_flush_ID, b_flush_EX, b_pc_redirect, b_fault;
  logic [31:0] b_stall_cnt, b_flush_cnt;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          n_tests;
  int          n_fail;
  int          vec_id;
  logic [31:0] m_stall[2];
  logic [31:0] m_flush[2];
  logic        known[2];

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(255), .CNT_W(32)) u_dut (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_addr_IF(rs1_addr_IF), .i_rs2_addr_IF(rs2_addr_IF),
    .i_use_rs1_IF(use_rs1_IF), .i_use_rs2_IF(use_rs2_IF),
    .i_rd_EX(rd_EX), .i_is_load_EX(is_load_EX), .i_redirect_EX(redirect_EX),
    .i_dm_req_MEM(dm_req_MEM), .i_dm_ready_MEM(dm_ready_MEM),
    .o_stall_IF(a_stall_IF), .o_stall_ID(a_stall_ID), .o_stall_EX(a_stall_EX),
    .o_flush_ID(a_flush_ID), .o_flush_EX(a_flush_EX), .o_pc_redirect(a_pc_redirect),
    .o_fault(a_fault), .o_stall_cnt(a_stall_cnt), .o_flush_cnt(a_flush_cnt)
  );

  pipeline_hazard_ctrl #(.REDIRECT_BUBBLES(2), .MEM_TIMEOUT(3), .CNT_W(32)) u_dut_to (
    .i_clk(clk), .i_reset(reset),
    .i_rs1_addr_IF(rs1_addr_IF), .i_rs2_addr_IF(rs2_addr_IF),
    .i_use_rs1_IF(use_rs1_IF), .i_use_rs2_IF(use_rs2_IF),
    .i_rd_EX(rd_EX), .i_is_load_EX(is_load_EX), .i_redirect_EX(redirect_EX),
    .i_dm_req_MEM(dm_req_MEM), .i_dm_ready_MEM(dm_ready_MEM),
    .o_stall_IF(b_stall_IF), .o_stall_ID(b_stall_ID), .o_stall_EX(b_stall_EX),
    .o_flush_ID(b_flush_ID), .o_flush_EX(b_flush_EX), .o_pc_redirect(b_pc_redirect),
    .o_fault(b_fault), .o_stall_cnt(b_stall_cnt), .o_flush_cnt(b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic sel, input logic rst, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic [4:0] rd, input logic ld, input logic rdr,
                              input logic req, input logic rdy, input logic [6:0] exp);
    vec_t v;
    v.sel = sel; v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.rd = rd; v.ld = ld; v.rdr = rdr; v.req = req; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic check_one();
    sb_t         e;
    logic [6:0]  act;
    logic [31:0] act_s, act_f;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty actual=0 entries required=1 entry");
      return;
    end
    e = sb.pop_front();
    if (e.sel) begin
      act   = {b_stall_IF, b_stall_ID, b_stall_EX, b_flush_ID, b_flush_EX, b_pc_redirect, b_fault};
      act_s = b_stall_cnt;
      act_f = b_flush_cnt;
    end else begin
      act   = {a_stall_IF, a_stall_ID, a_stall_EX, a_flush_ID, a_flush_EX, a_pc_redirect, a_fault};
      act_s = a_stall_cnt;
      act_f = a_flush_cnt;
    end
    if (act !== e.exp) begin
      n_fail++;
      $display("FAIL vec%0d_ctrl dut%0d actual=%b required=%b (stIF stID stEX flID flEX pcr flt)",
               e.id, e.sel, act, e.exp);
    end
    if (e.chk_cnt) begin
      n_tests++;
      if ({act_s, act_f} !== {e.exp_stall, e.exp_flush}) begin
        n_fail++;
        $display("FAIL vec%0d_cnt dut%0d actual stall=%0d flush=%0d required stall=%0d flush=%0d",
                 e.id, e.sel, act_s, act_f, e.exp_stall, e.exp_flush);
      end
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, sample at the falling edge
  task automatic step(input vec_t v);
    sb_t e;
    int  s;
    s = v.sel ? 1 : 0;
    @(posedge clk);
    #1;
    reset = v.rst; rs1_addr_IF = v.rs1; rs2_addr_IF = v.rs2;
    use_rs1_IF = v.u1; use_rs2_IF = v.u2; rd_EX = v.rd; is_load_EX = v.ld;
    redirect_EX = v.rdr; dm_req_MEM = v.req; dm_ready_MEM = v.rdy;
    e.id = vec_id; e.sel = v.sel; e.exp = v.exp; e.chk_cnt = known[s];
    e.exp_stall = m_stall[s]; e.exp_flush = m_flush[s];
    sb.push_back(e);
    if (v.rst) begin
      m_stall[s] = 32'd0;
      m_flush[s] = 32'd0;
      known[s]   = 1'b1;
    end else begin
      if (v.exp[6] && m_stall[s] != 32'hFFFF_FFFF) m_stall[s] = m_stall[s] + 32'd1;
      if (v.exp[3] && m_flush[s] != 32'hFFFF_FFFF) m_flush[s] = m_flush[s] + 32'd1;
    end
    known[1-s] = 1'b0;
    vec_id++;
    @(negedge clk);
    check_one();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; vec_id = 0;
    for (int i = 0; i < 2; i++) begin
      m_stall[i] = 32'd0; m_flush[i] = 32'd0; known[i] = 1'b0;
    end
    reset = 1'b1; rs1_addr_IF = 5'd0; rs2_addr_IF = 5'd0; use_rs1_IF = 1'b0; use_rs2_IF = 1'b0;
    rd_EX = 5'd0; is_load_EX = 1'b0; redirect_EX = 1'b0; dm_req_MEM = 1'b0; dm_ready_MEM = 1'b0;

    //                sel rst rs1   rs2   u1 u2 rd    ld rdr req rdy exp
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, O_LU));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd7, 0, 1, 5'd7, 1, 0, 0, 0, O_LU));
    tbl.push_back(mk(0, 0, 5'd0, 5'd7, 0, 0, 5'd7, 1, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RD0));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RD1));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 1, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RD0));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RD1));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 0, 0, O_LU));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RD0));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_RD1));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 1, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0, O_RD0));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    tbl.push_back(mk(0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_IDLE));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Timeout with MEM_TIMEOUT=3: fault after three waiting cycles, sticky until reset
    step(mk(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    for (int i = 0; i < 3; i++) step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_FT));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_FT));
    step(mk(1, 0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 1, 1, O_FT));
    step(mk(1, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, O_ST));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));
    step(mk(1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, O_IDLE));

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d entries required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
